// File: rtl/reg_mux_n.sv
// Registered N-to-1 channel multiplexer with valid/ready handshakes, select or round-robin grant.
// Optional feature macro: REG_MUX_RR_EN enables round-robin mode and its pointer register.
module reg_mux_n #(
    parameter int  WIDTH  = 5,
    parameter int  NUM_IN = 4,
    localparam int SEL_W  = (NUM_IN > 1) ? $clog2(NUM_IN) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [NUM_IN-1:0]       in_valid,
    output logic [NUM_IN-1:0]       in_ready,
    input  logic [SEL_W-1:0]        sel,
    input  logic                    mode,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [SEL_W-1:0]        out_src
);

    // Handshake: a word crosses a port only in a cycle where valid and ready are both high.
    // in_ready never looks at in_data, and in select mode it never looks at in_valid either.
    logic             load;
    logic             sel_ok;
    logic             grant_ok;
    logic [SEL_W-1:0] grant_idx;
    logic [WIDTH-1:0] grant_data;
    logic             xfer;

    // A select value past the last channel matches nothing and grants nobody.
    always_comb begin
        sel_ok = 1'b0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (sel == SEL_W'(i)) sel_ok = 1'b1;
        end
    end

`ifdef REG_MUX_RR_EN
    logic [SEL_W-1:0] ptr;
    logic             rr_ok;
    logic [SEL_W-1:0] rr_idx;

    // Lowest valid channel above ptr wins; otherwise wrap to the lowest valid at or below ptr.
    always_comb begin
        logic             hi_ok;
        logic             lo_ok;
        logic [SEL_W-1:0] hi_idx;
        logic [SEL_W-1:0] lo_idx;
        hi_ok  = 1'b0;
        lo_ok  = 1'b0;
        hi_idx = '0;
        lo_idx = '0;
        for (int i = NUM_IN - 1; i >= 0; i--) begin
            if (in_valid[i]) begin
                if (SEL_W'(i) > ptr) begin
                    hi_ok  = 1'b1;
                    hi_idx = SEL_W'(i);
                end else begin
                    lo_ok  = 1'b1;
                    lo_idx = SEL_W'(i);
                end
            end
        end
        rr_ok  = hi_ok | lo_ok;
        rr_idx = hi_ok ? hi_idx : lo_idx;
    end

    assign grant_ok  = mode ? rr_ok  : sel_ok;
    assign grant_idx = mode ? rr_idx : sel;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= SEL_W'(NUM_IN - 1);
        end else if (xfer && mode) begin
            ptr <= grant_idx;
        end
    end
`else
    logic unused_mode;
    assign unused_mode = mode;
    assign grant_ok    = sel_ok;
    assign grant_idx   = sel;
`endif

    assign load = !out_valid || out_ready;

    always_comb begin
        in_ready   = '0;
        grant_data = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (grant_idx == SEL_W'(i)) begin
                in_ready[i] = rst_n && grant_ok && load;
                grant_data  = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    assign xfer = |(in_ready & in_valid);

    // A new word may replace a draining one in the same cycle, giving one word per clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= '0;
        end else if (xfer) begin
            out_valid <= 1'b1;
            out_data  <= grant_data;
            out_src   <= grant_idx;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: doc/reg_mux_n.md
REG_MUX_N -- requirements
Module: reg_mux_n

Interface
REQ-001 Parameter WIDTH, default 5: data width per channel.
REQ-002 Parameter NUM_IN, default 4: number of input channels, 2..16.
REQ-003 Localparam SEL_W = max(1, clog2(NUM_IN)): width of select and source fields.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 in_data  input  NUM_IN*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
REQ-007 in_valid  input  NUM_IN  per-channel valid.
REQ-008 in_ready  output  NUM_IN  per-channel ready, combinational, at most one bit high.
REQ-009 sel  input  SEL_W  channel index used in select mode.
REQ-010 mode  input  1  0 = select mode, 1 = round-robin mode.
REQ-011 out_data  output  WIDTH  registered output data.
REQ-012 out_valid  output  1  output register holds a word.
REQ-013 out_ready  input  1  downstream accepts the word.
REQ-014 out_src  output  SEL_W  channel index that supplied out_data.

Function
REQ-015 load = !out_valid || out_ready; input transfer on channel i occurs when in_valid[i] && in_ready[i].
REQ-016 Select mode: in_ready[sel] = load; all other in_ready bits 0.
REQ-017 Select mode, sel >= NUM_IN: all in_ready 0, no transfer, out_valid clears once held word drains.
REQ-018 Round-robin mode: grant = first channel with in_valid set, searching from (ptr+1) mod NUM_IN upward with wrap; in_ready[grant] = load; none granted if no in_valid.
REQ-019 Round-robin pointer ptr updates to the granted index only on a transfer; unchanged otherwise.
REQ-020 On transfer: out_data <= in_data of granted channel, out_src <= its index, out_valid <= 1, one cycle latency.
REQ-021 No transfer and out_ready && out_valid: out_valid <= 0; out_data and out_src hold last value.
REQ-022 out_valid && !out_ready: out_data, out_src, out_valid hold stable; all in_ready 0.
REQ-023 Simultaneous drain and load in same cycle: new word replaces old, out_valid stays 1, full throughput (one word per cycle).
REQ-024 Changes to mode or sel take effect on the next cycle's grant; a held output word is never altered.
REQ-025 in_ready shall not depend on in_data; in select mode shall not depend on in_valid.

Reset
REQ-026 rst_n low asynchronously forces out_valid 0, out_data 0, out_src 0, ptr NUM_IN-1 (first round-robin priority is channel 0).
REQ-027 While rst_n low, all in_ready 0; reset asserted mid-transfer discards the held word.
REQ-028 Reset deassertion takes effect at the next rising clk edge; first transfer possible in that cycle.

Configuration
REQ-029 Macro REG_MUX_RR_EN defined: round-robin mode and ptr present as REQ-018/019.
REQ-030 Macro REG_MUX_RR_EN undefined: mode input ignored, block operates in select mode only, no ptr state.

Verification
REQ-031 WIDTH=5, NUM_IN=4, mode=0, sel=2, in_valid=4'b1111, ch2=5'h15, out_ready=1 -> next cycle out_data=5'h15, out_src=2, out_valid=1; in_ready=4'b0100.
REQ-032 mode=0, sel=1, out_ready=0 for 3 cycles after a load of 5'h0A -> out_data=5'h0A stable, in_ready=4'b0000 for those cycles; out_ready=1 -> next word loaded same cycle.
REQ-033 REG_MUX_RR_EN, mode=1, in_valid=4'b1111, out_ready=1 from reset -> out_src sequence 0,1,2,3,0 on consecutive cycles.
REQ-034 REG_MUX_RR_EN, mode=1, in_valid=4'b1010, ptr after grant 3 -> next grant 1, then 3; channels 0 and 2 never granted.
REQ-035 mode=0, sel=2 with NUM_IN=3... sel=3 with NUM_IN=3 -> in_ready all 0, out_valid falls after one out_ready cycle.
REQ-036 rst_n low mid-stall with out_valid=1 -> out_valid, out_data, out_src 0 immediately without a clock edge; ptr restarts at channel 0.
